// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode side bundle of the instruction fetch queue.
// The master modport is the fetch+decode pipeline, the slave modport is the queue.
interface inst_fetch_queue_if #(
    parameter int AW = 4
);
    logic          flush;
    logic          push1F;
    logic          push2F;
    logic [31:0]   pc1F;
    logic [31:0]   pc2F;
    logic [31:0]   inst1F;
    logic [31:0]   inst2F;
    logic          full_o;
    logic          valid1D;
    logic          valid2D;
    logic [31:0]   pc1D;
    logic [31:0]   pc2D;
    logic [31:0]   inst1D;
    logic [31:0]   inst2D;
    logic [1:0]    issue_cnt;
    logic [AW:0]   count_o;

    modport master (
        output flush, push1F, push2F, pc1F, pc2F, inst1F, inst2F, issue_cnt,
        input  full_o, valid1D, valid2D, pc1D, pc2D, inst1D, inst2D, count_o
    );

    modport slave (
        input  flush, push1F, push2F, pc1F, pc2F, inst1F, inst2F, issue_cnt,
        output full_o, valid1D, valid2D, pc1D, pc2D, inst1D, inst2D, count_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-push / dual-pop instruction queue between fetch and decode.
// Optional IQ_PERF_EN adds saturating full/empty cycle counters.
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_queue_if.slave    q
`ifdef IQ_PERF_EN
    ,
    output logic [31:0]          full_cycles,
    output logic [31:0]          empty_cycles
`endif
);

    localparam logic [AW:0] FULL_LIMIT = (AW+1)'(DEPTH - 2);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_p1;
    logic [AW-1:0] wr_ptr_p1;
    logic [AW:0]   count;
    logic          full;
    logic          accept;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;
    logic [1:0]    issue_eff;
    logic [63:0]   head0;
    logic [63:0]   head1;

    always_comb begin
        full      = count > FULL_LIMIT;
        accept    = !full && !q.flush;
        n_push    = 2'd0;
        if (accept && q.push1F) begin
            n_push = q.push2F ? 2'd2 : 2'd1;
        end
        issue_eff = (q.issue_cnt == 2'd3) ? 2'd2 : q.issue_cnt;
        // count < issue_eff implies count <= 1, so its low bits are exact
        n_pop     = (count < (AW+1)'(issue_eff)) ? count[1:0] : issue_eff;
        rd_ptr_p1 = rd_ptr + AW'(1);
        wr_ptr_p1 = wr_ptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && q.push1F) begin
            mem[wr_ptr] <= {q.pc1F, q.inst1F};
            if (q.push2F) begin
                mem[wr_ptr_p1] <= {q.pc2F, q.inst2F};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(n_pop);
            wr_ptr <= wr_ptr + AW'(n_push);
            count  <= count + (AW+1)'(n_push) - (AW+1)'(n_pop);
        end
    end

    // No bypass: outputs only ever show entries written in earlier cycles.
    always_comb begin
        head0     = mem[rd_ptr];
        head1     = mem[rd_ptr_p1];
        q.full_o  = full;
        q.count_o = count;
        q.valid1D = count != '0;
        q.valid2D = count > (AW+1)'(1);
        q.pc1D    = q.valid1D ? head0[63:32] : '0;
        q.inst1D  = q.valid1D ? head0[31:0]  : '0;
        q.pc2D    = q.valid2D ? head1[63:32] : '0;
        q.inst2D  = q.valid2D ? head1[31:0]  : '0;
    end

`ifdef IQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cycles  <= '0;
            empty_cycles <= '0;
        end else begin
            if (full && full_cycles != 32'hFFFF_FFFF) begin
                full_cycles <= full_cycles + 32'd1;
            end
            if (count == '0 && empty_cycles != 32'hFFFF_FFFF) begin
                empty_cycles <= empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.AW(AW)) bus ();

`ifdef IQ_PERF_EN
    logic [31:0] full_cycles;
    logic [31:0] empty_cycles;
`endif

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .q(bus)
`ifdef IQ_PERF_EN
        ,
        .full_cycles(full_cycles),
        .empty_cycles(empty_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] mq[$];
    logic [31:0] next_pc = 32'h0000_1000;
    int          last_acc;
    int          obs_full  = 0;
    int          obs_empty = 0;

    typedef struct {
        bit         r;
        bit         f;
        bit         p1;
        bit         p2;
        logic [1:0] ic;
        int         exp_cnt;
        bit         exp_v1;
        bit         exp_v2;
        bit         exp_full;
    } vec_t;

    vec_t tbl[10];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] e0, e1;
        int n;
        n  = mq.size();
        e0 = (n >= 1) ? mq[0] : 64'd0;
        e1 = (n >= 2) ? mq[1] : 64'd0;
        cmp("m_count", 32'(bus.count_o), n);
        cmp("m_full",  32'(bus.full_o), (n > DEPTH - 2) ? 1 : 0);
        cmp("m_valid1", 32'(bus.valid1D), (n >= 1) ? 1 : 0);
        cmp("m_valid2", 32'(bus.valid2D), (n >= 2) ? 1 : 0);
        cmp("m_pc1", bus.pc1D, e0[63:32]);
        cmp("m_inst1", bus.inst1D, e0[31:0]);
        cmp("m_pc2", bus.pc2D, e1[63:32]);
        cmp("m_inst2", bus.inst2D, e1[31:0]);
    endtask

    task automatic model_update();
        int  eff, npop;
        bit  mfull;
        mfull    = mq.size() > DEPTH - 2;
        last_acc = 0;
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            eff  = (bus.issue_cnt == 2'd3) ? 2 : int'(bus.issue_cnt);
            npop = (eff < mq.size()) ? eff : mq.size();
            repeat (npop) void'(mq.pop_front());
            if (!mfull && bus.push1F) begin
                mq.push_back({bus.pc1F, bus.inst1F});
                last_acc = 1;
                if (bus.push2F) begin
                    mq.push_back({bus.pc2F, bus.inst2F});
                    last_acc = 2;
                end
            end
        end
    endtask

    task automatic apply(input bit r, input bit f, input bit p1, input bit p2, input logic [1:0] ic);
        rst           = r;
        bus.flush     = f;
        bus.push1F    = p1;
        bus.push2F    = p2;
        bus.issue_cnt = ic;
        bus.pc1F      = next_pc;
        bus.pc2F      = next_pc + 32'd4;
        bus.inst1F    = $urandom;
        bus.inst2F    = $urandom;
    endtask

    task automatic tick(input bit chk);
        if (chk) check_model();
        if (rst) begin
            obs_full  = 0;
            obs_empty = 0;
        end else begin
            if (mq.size() > DEPTH - 2) obs_full++;
            if (mq.size() == 0) obs_empty++;
        end
        @(posedge clk);
        model_update();
        #1;
        next_pc = next_pc + 32'(4 * last_acc);
    endtask

    task automatic step(input bit r, input bit f, input bit p1, input bit p2, input logic [1:0] ic);
        apply(r, f, p1, p2, ic);
        tick(1'b1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2, 1'b1, 1'b1, 1'b0};

        apply(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);

        // Vector table: constant expectations after each edge, model checks data
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].r, tbl[i].f, tbl[i].p1, tbl[i].p2, tbl[i].ic);
            tick(i != 0);
            cmp($sformatf("tbl%0d_count", i), 32'(bus.count_o), tbl[i].exp_cnt);
            cmp($sformatf("tbl%0d_v1", i), 32'(bus.valid1D), 32'(tbl[i].exp_v1));
            cmp($sformatf("tbl%0d_v2", i), 32'(bus.valid2D), 32'(tbl[i].exp_v2));
            cmp($sformatf("tbl%0d_full", i), 32'(bus.full_o), 32'(tbl[i].exp_full));
        end
        check_model();

        // Reset then a single pair at the boot vector
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        cmp("rst_v1", 32'(bus.valid1D), 0);
        cmp("rst_full", 32'(bus.full_o), 0);
        cmp("rst_pc1", bus.pc1D, 0);
        next_pc = 32'hbfc0_0000;
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        cmp("boot_pc1", bus.pc1D, 32'hbfc0_0000);
        cmp("boot_pc2", bus.pc2D, 32'hbfc0_0004);
        cmp("boot_count", 32'(bus.count_o), 2);

        // Fill: 14 entries is not full, 16 is; further pushes dropped
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        cmp("fill14_count", 32'(bus.count_o), 14);
        cmp("fill14_full", 32'(bus.full_o), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        cmp("fill16_count", 32'(bus.count_o), 16);
        cmp("fill16_full", 32'(bus.full_o), 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        cmp("drop_count", 32'(bus.count_o), 16);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
        cmp("full_pop_count", 32'(bus.count_o), 14);

        // Flush beats same-cycle push and issue
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        cmp("pre_flush_count", 32'(bus.count_o), 10);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
        cmp("flush_count", 32'(bus.count_o), 0);
        cmp("flush_v1", 32'(bus.valid1D), 0);
        next_pc = 32'h8000_0100;
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        cmp("redirect_pc1", bus.pc1D, 32'h8000_0100);

        // 40 pairs with alternating issue 1/2 across pointer wrap
        begin
            int          pairs;
            int          retired;
            int          cyc;
            int          eff;
            int          n;
            logic [31:0] exp_pc;
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            next_pc = 32'h0040_0000;
            exp_pc  = next_pc;
            pairs   = 0;
            retired = 0;
            cyc     = 0;
            while ((pairs < 40 || mq.size() != 0) && cyc < 400) begin
                bit do_push;
                do_push = (pairs < 40) && !(mq.size() > DEPTH - 2);
                apply(1'b0, 1'b0, do_push, do_push, (cyc % 2 == 0) ? 2'd1 : 2'd2);
                eff = (cyc % 2 == 0) ? 1 : 2;
                n   = (eff < mq.size()) ? eff : mq.size();
                for (int k = 0; k < n; k++) begin
                    cmp("order_pc", (k == 0) ? bus.pc1D : bus.pc2D, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    retired++;
                end
                tick(1'b1);
                if (do_push) pairs++;
                cyc++;
            end
            cmp("wrap_retired", retired, 80);
`ifdef IQ_PERF_EN
            cmp("perf_full", full_cycles, obs_full);
            cmp("perf_empty", empty_cycles, obs_empty);
`endif
        end

        // Random traffic against the reference model
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 600; i++) begin
            bit r, f;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 29) == 0);
            if (f) next_pc = {$urandom_range(0, 65535), 16'h0000};
            step(r, f, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)));
        end
        check_model();
`ifdef IQ_PERF_EN
        cmp("perf_full_rand", full_cycles, obs_full);
        cmp("perf_empty_rand", empty_cycles, obs_empty);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
